// File: rtl/spike_rate_decoder.sv
// Decodes a neuron's 1-bit spike stream into a per-window spike count and the
// most recent inter-spike interval, presented through a one-deep valid/ready register.
module spike_rate_decoder #(
  parameter int WINDOW_W = 16,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [COUNT_W-1:0]  rate_out,
  output logic [WINDOW_W-1:0] isi_out,
  output logic                overflow,
  output logic                overrun
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic                spike_prev_reg;
  logic [WINDOW_W-1:0] len_reg, len_next;
  logic [WINDOW_W-1:0] win_cnt_reg, win_cnt_next;
  logic [COUNT_W-1:0]  count_reg, count_inc;
  logic                sat_reg, sat_inc;
  logic [WINDOW_W-1:0] since_reg, since_inc;
  logic                seen_spike_reg;
  logic [WINDOW_W-1:0] isi_reg, isi_upd;

  logic                out_valid_reg;
  logic [COUNT_W-1:0]  rate_reg;
  logic [WINDOW_W-1:0] isi_out_reg;
  logic                overflow_reg;
  logic                overrun_reg;

  logic                spike_edge;
  logic                win_active;
  logic [WINDOW_W-1:0] cur_len;
  logic [WINDOW_W-1:0] cur_idx;
  logic                close_win;

  assign spike_edge = ena && spike_in && !spike_prev_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE leaves on the first enabled cycle with a nonzero
  // length; COUNT re-latches the length at every window close.
  always_comb begin
    state_next = state_reg;
    if (ena && ((state_reg == IDLE) || close_win)) begin
      state_next = (window_len != '0) ? COUNT : IDLE;
    end
  end

  // Output/decode logic. In IDLE the current cycle is window cycle 0 of a
  // window whose length is taken straight from window_len, so L=1 closes at once.
  always_comb begin
    win_active = (state_reg == COUNT) || (window_len != '0);
    cur_len    = (state_reg == COUNT) ? len_reg : window_len;
    cur_idx    = (state_reg == COUNT) ? win_cnt_reg : '0;
    close_win  = ena && win_active && (cur_idx == (cur_len - WINDOW_W'(1)));
  end

  always_comb begin
    len_next     = len_reg;
    win_cnt_next = win_cnt_reg;
    if (ena && win_active) begin
      if (close_win) begin
        len_next     = window_len;
        win_cnt_next = '0;
      end else begin
        len_next     = cur_len;
        win_cnt_next = cur_idx + WINDOW_W'(1);
      end
    end
  end

  // Spike count including the current cycle's edge, saturating; an edge that
  // finds the counter already full marks the window as overflowed.
  always_comb begin
    count_inc = count_reg;
    sat_inc   = sat_reg;
    if (spike_edge && win_active) begin
      if (&count_reg) begin
        sat_inc = 1'b1;
      end else begin
        count_inc = count_reg + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    since_inc = (&since_reg) ? since_reg : since_reg + WINDOW_W'(1);
    isi_upd   = isi_reg;
    if (spike_edge && seen_spike_reg) begin
      isi_upd = since_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_prev_reg <= 1'b0;
      len_reg        <= '0;
      win_cnt_reg    <= '0;
      count_reg      <= '0;
      sat_reg        <= 1'b0;
      since_reg      <= '0;
      seen_spike_reg <= 1'b0;
      isi_reg        <= '0;
    end else if (ena) begin
      spike_prev_reg <= spike_in;
      len_reg        <= len_next;
      win_cnt_reg    <= win_cnt_next;
      isi_reg        <= isi_upd;
      if (close_win) begin
        count_reg <= '0;
        sat_reg   <= 1'b0;
      end else begin
        count_reg <= count_inc;
        sat_reg   <= sat_inc;
      end
      if (spike_edge) begin
        since_reg      <= '0;
        seen_spike_reg <= 1'b1;
      end else begin
        since_reg <= since_inc;
      end
    end
  end

  // Result register: a capture always wins; it flags overrun only when the
  // previous result is still pending and not being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      rate_reg      <= '0;
      isi_out_reg   <= '0;
      overflow_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (close_win) begin
      out_valid_reg <= 1'b1;
      rate_reg      <= count_inc;
      isi_out_reg   <= isi_upd;
      overflow_reg  <= sat_inc;
      overrun_reg   <= out_valid_reg && !out_ready;
    end else begin
      overrun_reg <= 1'b0;
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign rate_out  = rate_reg;
  assign isi_out   = isi_out_reg;
  assign overflow  = overflow_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a timestamp-based reference model is
// checked every cycle, plus literal expectations at key points.
module tb_spike_rate_decoder;
  localparam int WINDOW_W = 16;
  localparam int COUNT_W  = 8;
  localparam int CNT_MAX  = (1 << COUNT_W) - 1;
  localparam int ISI_MAX  = (1 << WINDOW_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                ena;
  logic                spike_in;
  logic [WINDOW_W-1:0] window_len;
  logic                out_ready;
  logic                out_valid;
  logic [COUNT_W-1:0]  rate_out;
  logic [WINDOW_W-1:0] isi_out;
  logic                overflow;
  logic                overrun;

  spike_rate_decoder #(.WINDOW_W(WINDOW_W), .COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rate_out   (rate_out),
    .isi_out    (isi_out),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_seen = 0;
  int vld_seen = 0;

  // Reference model: time is counted in enabled cycles; a window is a start
  // time plus a length, and ISI is the distance between edge timestamps.
  int m_t, m_last, m_isi, m_start, m_len, m_edges;
  bit m_prev, m_have, m_inwin;
  bit m_valid, m_ovf, m_overrun;
  int m_rate, m_isi_out;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit e, cap;
    int c_rate, c_isi;
    bit c_ovf;
    cap = 0; c_rate = 0; c_isi = 0; c_ovf = 0;
    if (rst) begin
      m_prev = 0; m_t = 0; m_have = 0; m_last = 0; m_isi = 0;
      m_inwin = 0; m_start = 0; m_len = 0; m_edges = 0;
      m_valid = 0; m_rate = 0; m_isi_out = 0; m_ovf = 0; m_overrun = 0;
    end else begin
      if (ena) begin
        e = spike_in && !m_prev;
        m_prev = spike_in;
        if (!m_inwin && window_len != 0) begin
          m_inwin = 1; m_len = int'(window_len); m_start = m_t; m_edges = 0;
        end
        if (e) begin
          if (m_have) m_isi = (m_t - m_last > ISI_MAX) ? ISI_MAX : m_t - m_last;
          m_have = 1;
          m_last = m_t;
        end
        if (m_inwin) begin
          if (e) m_edges++;
          if (m_t - m_start == m_len - 1) begin
            cap = 1;
            c_rate = (m_edges > CNT_MAX) ? CNT_MAX : m_edges;
            c_ovf  = (m_edges > CNT_MAX);
            c_isi  = m_isi;
            m_edges = 0;
            if (window_len != 0) begin
              m_len = int'(window_len); m_start = m_t + 1;
            end else begin
              m_inwin = 0;
            end
          end
        end
        m_t++;
      end
      if (cap) begin
        m_overrun = m_valid && !out_ready;
        m_valid = 1; m_rate = c_rate; m_ovf = c_ovf; m_isi_out = c_isi;
      end else begin
        m_overrun = 0;
        if (m_valid && out_ready) m_valid = 0;
      end
    end
  endtask

  // One clock: advance the model on the inputs the DUT will sample, then
  // compare every output just after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("rate_out",  int'(rate_out),  m_rate);
    check("isi_out",   int'(isi_out),   m_isi_out);
    check("overflow",  int'(overflow),  int'(m_ovf));
    check("overrun",   int'(overrun),   int'(m_overrun));
    if (overrun) ovr_seen++;
    if (out_valid) vld_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; spike_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; spike_in = 1'b0; window_len = 16'd10; out_ready = 1'b0;
    repeat (2) step();
    check("reset_valid", int'(out_valid), 0);
    check("reset_rate",  int'(rate_out), 0);
    check("reset_isi",   int'(isi_out), 0);
    rst = 1'b0;

    // Spikes on window cycles 0,3,6,9
    for (int i = 0; i < 10; i++) begin
      spike_in = (i % 3 == 0);
      step();
    end
    check("t1_valid", int'(out_valid), 1);
    check("t1_rate",  int'(rate_out), 4);
    check("t1_isi",   int'(isi_out), 3);
    check("t1_ovf",   int'(overflow), 0);

    // Mid-window length change applies only at the next latch point
    spike_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) window_len = 16'd4;
      step();
    end
    check("t1b_valid", int'(out_valid), 1);
    check("t1b_rate",  int'(rate_out), 0);
    repeat (3) step();
    check("t1c_valid", int'(out_valid), 0);
    step();
    check("t1d_valid", int'(out_valid), 1);

    // Level-held spike counts once
    do_reset();
    window_len = 16'd10; out_ready = 1'b1; spike_in = 1'b1;
    repeat (10) step();
    check("t2_rate1", int'(rate_out), 1);
    check("t2_isi1",  int'(isi_out), 0);
    repeat (10) step();
    check("t2_rate2", int'(rate_out), 0);
    check("t2_isi2",  int'(isi_out), 0);

    // Saturation: 300 edges in a 600-cycle window, then a quiet window
    do_reset();
    window_len = 16'd600;
    for (int i = 0; i < 600; i++) begin
      spike_in = (i % 2 == 0);
      step();
    end
    check("t3_rate", int'(rate_out), 255);
    check("t3_ovf",  int'(overflow), 1);
    spike_in = 1'b0;
    repeat (600) step();
    check("t3_rate_q", int'(rate_out), 0);
    check("t3_ovf_q",  int'(overflow), 0);

    // Backpressure across two windows
    do_reset();
    window_len = 16'd10; out_ready = 1'b0; ovr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      spike_in = (i == 1 || i == 4);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      spike_in = (i % 2 == 0);
      step();
    end
    check("t4_valid",   int'(out_valid), 1);
    check("t4_rate",    int'(rate_out), 5);
    check("t4_overrun", int'(overrun), 1);
    spike_in = 1'b0; out_ready = 1'b1;
    step();
    check("t4_valid_clr", int'(out_valid), 0);
    check("t4_ovr_once",  ovr_seen, 1);

    // Disabled cycles stretch the window and never count
    do_reset();
    window_len = 16'd10; out_ready = 1'b1; spike_in = 1'b0;
    repeat (3) step();
    ena = 1'b0;
    for (int j = 0; j < 5; j++) begin
      spike_in = (j % 2 == 0);
      step();
    end
    ena = 1'b1; spike_in = 1'b0;
    repeat (6) step();
    check("t5_not_yet", int'(out_valid), 0);
    step();
    check("t5_valid", int'(out_valid), 1);
    check("t5_rate",  int'(rate_out), 0);

    // Reset mid-window discards the partial window
    do_reset();
    window_len = 16'd10; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spike_in = (i == 1 || i == 3);
      step();
    end
    rst = 1'b1; spike_in = 1'b0;
    step();
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_rate",  int'(rate_out), 0);
    check("t6_rst_isi",   int'(isi_out), 0);
    check("t6_rst_ovr",   int'(overrun), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_in = (i == 2 || i == 5);
      step();
    end
    check("t6_rate", int'(rate_out), 2);
    check("t6_isi",  int'(isi_out), 3);

    // Zero length never opens a window
    do_reset();
    window_len = 16'd0; out_ready = 1'b0; vld_seen = 0;
    for (int i = 0; i < 30; i++) begin
      spike_in = (i % 3 == 0);
      step();
    end
    check("t7_never_valid", vld_seen, 0);

    // Length 1: every enabled cycle closes a window, capture meets acceptance
    window_len = 16'd1; out_ready = 1'b1; ovr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      spike_in = (i == 0 || i == 2 || i == 3);
      step();
    end
    check("t8_valid", int'(out_valid), 1);
    check("t8_rate",  int'(rate_out), 0);
    check("t8_ovr",   ovr_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
